// File: rtl/test_ctrl_pkg.sv
// Shared types and constants for the memory-checker test sequencer.
// Holds the command payload, the mode enums and the address LFSR taps.
package test_ctrl_pkg;

    localparam int unsigned CMP_ADDR_W  = 16;
    localparam int unsigned AMM_BURST_W = 8;
    localparam int unsigned CMP_OFF_W   = 2;
    localparam int unsigned PTRN_W      = 8;
    localparam int unsigned LFSR_W      = 32;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic TRANS_WRITE = 1'b1;
    localparam logic TRANS_READ  = 1'b0;

    typedef enum logic [1:0] {
        TEST_NONE            = 2'b00,
        TEST_WRITE_ONLY      = 2'b01,
        TEST_READ_ONLY       = 2'b10,
        TEST_WRITE_AND_CHECK = 2'b11
    } test_mode_t;

    typedef enum logic [2:0] {
        ADDR_FIX   = 3'd0,
        ADDR_INC   = 3'd1,
        ADDR_RUN_1 = 3'd2,
        ADDR_RUN_0 = 3'd3,
        ADDR_RND   = 3'd4
    } addr_mode_t;

    typedef enum logic {
        DATA_FIX = 1'b0,
        DATA_RND = 1'b1
    } data_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic                   trans_type;
        logic [CMP_ADDR_W-1:0]  addr;
        logic [AMM_BURST_W-2:0] words_count;
        logic [CMP_OFF_W-1:0]   start_off;
        logic [CMP_OFF_W-1:0]   end_off;
        data_mode_t             data_mode;
        logic [PTRN_W-1:0]      data_ptrn;
    } cmp_struct_t;

    // Full-word command: offsets always span the whole word
    function automatic cmp_struct_t make_cmd(
        input logic                   trans_type,
        input logic [CMP_ADDR_W-1:0]  addr,
        input logic [AMM_BURST_W-2:0] words,
        input data_mode_t             data_mode,
        input logic [PTRN_W-1:0]      data_ptrn
    );
        cmp_struct_t c;
        c.trans_type  = trans_type;
        c.addr        = addr;
        c.words_count = words;
        c.start_off   = '0;
        c.end_off     = '1;
        c.data_mode   = data_mode;
        c.data_ptrn   = data_ptrn;
        return c;
    endfunction

endpackage

// File: rtl/test_addr_gen.sv
// Address generator for the test sequencer: FIX, INC, walking one/zero and LFSR.
// addr_c shows the step-0 address on init, the next address on step, else the current one.
module test_addr_gen
    import test_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  addr_mode_t             mode_i,
    input  logic [CMP_ADDR_W-1:0]  base_i,
    input  logic [AMM_BURST_W-2:0] words_i,
    input  logic                   init_i,
    input  logic                   step_i,
    output logic [CMP_ADDR_W-1:0]  addr_c
);

    localparam int unsigned AW = CMP_ADDR_W;

    addr_mode_t             r_mode;
    logic [AMM_BURST_W-2:0] r_words;
    logic [LFSR_W-1:0]      r_lfsr;
    logic [AW-1:0]          r_addr;
    logic [LFSR_W-1:0]      w_lfsr_nxt;
    logic [LFSR_W-1:0]      w_seed;

    always_comb begin
        w_lfsr_nxt = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : LFSR_W'(0));
        w_seed     = (base_i == '0) ? LFSR_W'(1) : LFSR_W'(base_i);
        addr_c     = r_addr;
        if (init_i) begin
            case (mode_i)
                ADDR_RUN_1: addr_c = AW'(1);
                ADDR_RUN_0: addr_c = ~AW'(1);
                ADDR_RND:   addr_c = w_seed[AW-1:0];
                default:    addr_c = base_i;
            endcase
        end else if (step_i) begin
            case (r_mode)
                ADDR_INC:               addr_c = r_addr + AW'(r_words) + AW'(1);
                ADDR_RUN_1, ADDR_RUN_0: addr_c = {r_addr[AW-2:0], r_addr[AW-1]};
                ADDR_RND:               addr_c = w_lfsr_nxt[AW-1:0];
                default:                addr_c = r_addr;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mode  <= ADDR_FIX;
            r_words <= '0;
            r_lfsr  <= LFSR_W'(1);
            r_addr  <= '0;
        end else if (init_i) begin
            r_mode  <= mode_i;
            r_words <= words_i;
            r_lfsr  <= w_seed;
            r_addr  <= addr_c;
        end else if (step_i) begin
            r_lfsr  <= w_lfsr_nxt;
            r_addr  <= addr_c;
        end
    end

endmodule

// File: rtl/test_ctrl.sv
// Test sequencer: issues write/read commands per address step, tracks reads in
// flight against comparator completions and reports finish and pass/fail.
module test_ctrl
    import test_ctrl_pkg::*;
#(
    parameter int unsigned TRANS_CNT_W = 16,
    parameter int unsigned MAX_OUTST   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  test_mode_t             test_mode_i,
    input  addr_mode_t             addr_mode_i,
    input  data_mode_t             data_mode_i,
    input  logic [PTRN_W-1:0]      data_ptrn_i,
    input  logic [CMP_ADDR_W-1:0]  base_addr_i,
    input  logic [AMM_BURST_W-2:0] words_i,
    input  logic [TRANS_CNT_W-1:0] trans_cnt_i,
    output logic                   cmd_valid_o,
    input  logic                   cmd_ready_i,
    output cmp_struct_t            cmd_o,
    input  logic                   rd_done_i,
    input  logic                   err_i,
    output logic                   busy_o,
    output logic                   finish_o,
    output logic                   result_o
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned TW = TRANS_CNT_W;

    ctrl_state_t            r_state;
    test_mode_t             r_mode;
    data_mode_t             r_dmode;
    logic [PTRN_W-1:0]      r_ptrn;
    logic [AMM_BURST_W-2:0] r_words;
    logic [TW-1:0]          r_trans_cnt;
    logic [TW-1:0]          r_k;
    logic                   r_phase;
    logic                   r_err;
    logic [OW-1:0]          r_outst;

    logic                   w_accept;
    logic                   w_acc_rd;
    logic                   w_dec;
    logic                   w_err_set;
    logic [OW-1:0]          w_outst_nxt;
    logic                   w_step_end;
    logic                   w_last;
    logic                   w_zero_test;
    logic                   w_first_type;
    logic                   w_nxt_type;
    logic [CMP_ADDR_W-1:0]  w_nxt_addr;
    logic                   w_nxt_phase;
    logic [TW-1:0]          w_nxt_k;
    logic                   w_nxt_blocked;
    logic                   w_pend_blocked;
    logic                   w_gen_init;
    logic                   w_gen_step;
    logic [CMP_ADDR_W-1:0]  w_addr_c;

    // Handshake and outstanding-read bookkeeping
    always_comb begin
        w_accept    = cmd_valid_o & cmd_ready_i;
        w_acc_rd    = w_accept & (cmd_o.trans_type == TRANS_READ);
        w_dec       = rd_done_i & (r_outst != '0);
        w_err_set   = rd_done_i & err_i;
        w_outst_nxt = r_outst + OW'(w_acc_rd) - OW'(w_dec);
    end

    // Command that follows the one being accepted
    always_comb begin
        w_zero_test  = (trans_cnt_i == '0) | (test_mode_i == TEST_NONE);
        w_first_type = (test_mode_i == TEST_READ_ONLY) ? TRANS_READ : TRANS_WRITE;
        w_step_end   = (r_mode != TEST_WRITE_AND_CHECK) | r_phase;
        w_last       = w_step_end & (r_k == r_trans_cnt - TW'(1));
        w_nxt_type   = cmd_o.trans_type;
        w_nxt_addr   = w_addr_c;
        w_nxt_phase  = 1'b0;
        w_nxt_k      = r_k + TW'(1);
        if (r_mode == TEST_WRITE_AND_CHECK) begin
            if (!r_phase) begin
                w_nxt_type  = TRANS_READ;
                w_nxt_addr  = cmd_o.addr;
                w_nxt_phase = 1'b1;
                w_nxt_k     = r_k;
            end else begin
                w_nxt_type  = TRANS_WRITE;
            end
        end
        w_nxt_blocked  = (w_nxt_type == TRANS_READ) & (w_outst_nxt == OW'(MAX_OUTST));
        w_pend_blocked = (cmd_o.trans_type == TRANS_READ) & (w_outst_nxt == OW'(MAX_OUTST));
        w_gen_init     = (r_state == ST_IDLE) & start_i;
        w_gen_step     = (r_state == ST_ISSUE) & w_accept & w_step_end & ~w_last & ~r_err;
    end

    test_addr_gen u_addr_gen (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .mode_i  (addr_mode_i),
        .base_i  (base_addr_i),
        .words_i (words_i),
        .init_i  (w_gen_init),
        .step_i  (w_gen_step),
        .addr_c  (w_addr_c)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_mode      <= TEST_NONE;
            r_dmode     <= DATA_FIX;
            r_ptrn      <= '0;
            r_words     <= '0;
            r_trans_cnt <= '0;
            r_k         <= '0;
            r_phase     <= 1'b0;
            r_err       <= 1'b0;
            r_outst     <= '0;
            cmd_valid_o <= 1'b0;
            cmd_o       <= '0;
            busy_o      <= 1'b0;
            finish_o    <= 1'b0;
            result_o    <= 1'b0;
        end else begin
            r_outst  <= w_outst_nxt;
            finish_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_mode      <= test_mode_i;
                        r_dmode     <= data_mode_i;
                        r_ptrn      <= data_ptrn_i;
                        r_words     <= words_i;
                        r_trans_cnt <= trans_cnt_i;
                        r_k         <= '0;
                        r_phase     <= 1'b0;
                        r_err       <= 1'b0;
                        busy_o      <= 1'b1;
                        result_o    <= 1'b0;
                        if (w_zero_test) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state     <= ST_ISSUE;
                            cmd_valid_o <= 1'b1;
                            cmd_o       <= make_cmd(w_first_type, w_addr_c, words_i,
                                                    data_mode_i, data_ptrn_i);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_err_set) r_err <= 1'b1;
                    if (cmd_valid_o) begin
                        if (cmd_ready_i) begin
                            // An earlier error abandons the remaining steps
                            if (r_err | w_last) begin
                                cmd_valid_o <= 1'b0;
                                r_state     <= ST_DRAIN;
                            end else begin
                                cmd_o       <= make_cmd(w_nxt_type, w_nxt_addr, r_words,
                                                        r_dmode, r_ptrn);
                                cmd_valid_o <= ~w_nxt_blocked;
                                r_phase     <= w_nxt_phase;
                                r_k         <= w_nxt_k;
                            end
                        end
                    end else if (!w_pend_blocked) begin
                        cmd_valid_o <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_err_set) r_err <= 1'b1;
                    if (r_outst == '0) begin
                        r_state  <= ST_DONE;
                        finish_o <= 1'b1;
                        busy_o   <= 1'b0;
                        result_o <= r_err;
                    end
                end
                ST_DONE: begin
                    // Entered straight from IDLE the pulse has not fired yet
                    if (finish_o) begin
                        r_state <= ST_IDLE;
                    end else begin
                        finish_o <= 1'b1;
                        busy_o   <= 1'b0;
                        result_o <= r_err;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/test_ctrl.md
# test_ctrl

Test sequencer for the memory checker. It takes the test parameters latched from the CSR block (test mode, address mode, data mode, pattern, base address, transaction count) and issues a stream of `cmp_struct_t` commands to the Avalon-MM transaction generator. In WRITE_AND_CHECK mode each write command is paired with a read command to the same address. It tracks outstanding reads against comparator completions and reports test finish and pass/fail back to the CSR block.

## Interface
Parameters:
- `TRANS_CNT_W`, default 16: width of the transaction count.
- `MAX_OUTST`, default 16: maximum reads in flight, i.e. issued but with no `rd_done_i` yet.

Ports:
- `clk_i` in 1: system clock; the only clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: one-cycle start pulse; honoured only in IDLE.
- `test_mode_i` in 2 (`test_mode_t`), `addr_mode_i` in 3 (`addr_mode_t`), `data_mode_i` in 1 (`data_mode_t`), `data_ptrn_i` in 8: test settings, sampled on accepted start.
- `base_addr_i` in CMP_ADDR_W: base word address / LFSR seed, sampled on start.
- `words_i` in AMM_BURST_W-1: `words_count` placed in every command, sampled on start.
- `trans_cnt_i` in TRANS_CNT_W: number of address steps, sampled on start.
- `cmd_valid_o` out 1 / `cmd_ready_i` in 1: command handshake.
- `cmd_o` out `cmp_struct_t`: command. `trans_type` is 1 for write and 0 for read; `start_off` = 0; `end_off` = all ones.
- `rd_done_i` in 1: comparator finished one read transaction.
- `err_i` in 1: comparator mismatch, qualified by `rd_done_i`.
- `busy_o` out 1: high from accepted start until `finish_o`.
- `finish_o` out 1: one-cycle pulse at test end.
- `result_o` out 1: 0 = pass, 1 = error. Held until the next accepted start.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on `start_i`. Settings are latched, the step counter k is cleared, and the error flag is cleared.
- IDLE → DONE directly if `trans_cnt_i` = 0 or `test_mode_i` = 2'b00. No commands are issued and `result_o` = 0.
- ISSUE, WRITE_ONLY: one write per step.
- ISSUE, READ_ONLY: one read per step.
- ISSUE, WRITE_AND_CHECK: a write, then a read to the same address (phase bit). The step advances after the read is accepted.
- Address of step k, generated by the `test_addr_gen` sub-module:
  - FIX: base.
  - INC: base + k·(`words_i`+1), modulo 2^CMP_ADDR_W (wraps).
  - RUN_1: one-hot at bit k mod CMP_ADDR_W.
  - RUN_0: all ones except bit k mod CMP_ADDR_W.
  - RND: 32-bit Galois LFSR (taps 32,22,2,1), low CMP_ADDR_W bits. Seeded with base, or with 1 if base = 0. Advances one step per address step.
- Outstanding counter, 0..MAX_OUTST:
  - +1 on read acceptance, −1 on `rd_done_i`; both in one cycle leave it unchanged.
  - `rd_done_i` at 0 is ignored (no underflow).
  - A read command is not presented while the counter = MAX_OUTST; writes are not throttled.
- `err_i` & `rd_done_i` sets the sticky error flag. After the next command acceptance, ISSUE → DRAIN; the remaining steps are abandoned.
- ISSUE → DRAIN when the last command of step `trans_cnt`−1 is accepted.
- DRAIN → DONE when outstanding = 0. Errors still arriving in DRAIN set the flag.
- DONE: `finish_o` = 1 and `result_o` = error flag; next cycle → IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, LFSR 1. Reset mid-test aborts immediately, with no finish pulse.
- All outputs are registered.
- `start_i` at cycle 0 → `busy_o` and the first `cmd_valid_o` at cycle 1.
- Back-to-back acceptance gives one command per cycle. `cmd_o` updates on the accepting edge.
- While `cmd_valid_o` & !`cmd_ready_i`, `cmd_o` and `cmd_valid_o` stay stable. Valid is never withdrawn before acceptance, including on error or when throttled mid-offer.
- `start_i` while busy is ignored.
- `finish_o` is asserted one cycle after the DRAIN exit condition. `busy_o` falls in the same cycle that `finish_o` rises.

## Structure
- Shared package additions: `ctrl_state_t` enum; constants `TRANS_WRITE` = 1 and `TRANS_READ` = 0; LFSR tap constant.
- `test_mode_t`, `addr_mode_t`, `data_mode_t` and `cmp_struct_t` are reused from the package.
- One sub-module, `test_addr_gen`: inputs mode, base, words, `init`, `step`; output is the current address.

## Test plan
- WRITE_ONLY, FIX, base 0x100, trans_cnt 4, ready always 1 → 4 writes at 0x100 on cycles 1–4; `finish_o` on cycle 6; `result_o` = 0.
- WRITE_AND_CHECK, INC, base 0x10, words 3, trans_cnt 3 → W10, R10, W14, R14, W18, R18. Three `rd_done_i` pulses → finish pass.
- READ_ONLY, RUN_1, MAX_OUTST 2, `rd_done_i` withheld → only 2 reads (addresses 0x1, 0x2), then `cmd_valid_o` held low. One `rd_done_i` → the 3rd read (0x4) issues.
- INC near top of the address range → address wraps to 0; `cmd_o` held stable over a 5-cycle `cmd_ready_i` = 0 stall.
- `err_i` on the 2nd `rd_done_i` of a trans_cnt 10 test → issue stops after the next acceptance, drain completes, `result_o` = 1. A further `start_i` clears the result.
- trans_cnt 0 → `finish_o` at cycle 2, no commands. `rst_n_i` low mid-ISSUE → all outputs 0 asynchronously, no finish pulse.
